adbg_toggle_req_tx: RTL and testbench

Toggle-handshake request transmitter: the sending end of the debug unit's two-phase toggle CDC protocol. It captures a data word on a one-cycle request strobe and signals the request by inverting a level-held toggle line. It then waits for the far-end receiver to echo the toggle back, synchronizing that acknowledge internally. It sits on the debug-side domain and drives the toggle receiver in the CPU/bus domain.

---
 rtl/adbg_toggle_req_tx.sv | 148 ++++++++++++++
 tb/tb_adbg_toggle_req_tx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/adbg_toggle_req_tx.sv
// Sending end of the debug two-phase toggle handshake: captures a word on REQ_IN,
// flips TOGGLE_OUT, and waits for the synchronized echo (or a timeout) before accepting again.
module adbg_toggle_req_tx #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  DEST_CLK,
  input  logic                  RESET,
  input  logic                  REQ_IN,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  CLR_ERR,
  input  logic                  ACK_TOGGLE_IN,
  output logic                  TOGGLE_OUT,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  TIMEOUT,
  output logic                  DROP,
  output logic                  ERR
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic                    ack_s1;
  logic                    ack_s2;
  logic                    ack_prev;
  logic                    ack_edge_s;
  logic                    timeout_hit_s;
  logic [CW-1:0]           count_r;
  logic [CW-1:0]           count_nxt_s;
  logic                    toggle_nxt_s;
  logic [DATA_WIDTH-1:0]   data_nxt_s;
  logic                    done_nxt_s;
  logic                    timeout_nxt_s;
  logic                    drop_nxt_s;
  logic                    err_nxt_s;

  // Ack synchronizer plus edge-detect flop; the echo is asynchronous to DEST_CLK.
  always_ff @(posedge DEST_CLK or posedge RESET) begin
    if (RESET) begin
      ack_s1   <= 1'b0;
      ack_s2   <= 1'b0;
      ack_prev <= 1'b0;
    end else begin
      ack_s1   <= ACK_TOGGLE_IN;
      ack_s2   <= ack_s1;
      ack_prev <= ack_s2;
    end
  end

  assign ack_edge_s    = ack_s2 ^ ack_prev;
  assign timeout_hit_s = (TIMEOUT_CYCLES != 0) && (count_r == LIM);
  assign BUSY          = (state_r == WAIT_ACK);

  // State register.
  always_ff @(posedge DEST_CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: an ack edge takes priority over a coincident timeout.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (REQ_IN) state_nxt_s = WAIT_ACK;
        else        state_nxt_s = IDLE;
      end
      WAIT_ACK: begin
        if (ack_edge_s || timeout_hit_s) state_nxt_s = IDLE;
        else                             state_nxt_s = WAIT_ACK;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output/datapath next values; the toggle is left as-is on timeout.
  always_comb begin
    toggle_nxt_s  = TOGGLE_OUT;
    data_nxt_s    = DATA_OUT;
    count_nxt_s   = count_r;
    done_nxt_s    = 1'b0;
    timeout_nxt_s = 1'b0;
    drop_nxt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (REQ_IN) begin
          toggle_nxt_s = ~TOGGLE_OUT;
          data_nxt_s   = DATA_IN;
          count_nxt_s  = '0;
        end else begin
          count_nxt_s  = count_r;
        end
      end
      WAIT_ACK: begin
        drop_nxt_s = REQ_IN;
        if (ack_edge_s) begin
          done_nxt_s = 1'b1;
        end else if (timeout_hit_s) begin
          timeout_nxt_s = 1'b1;
        end else if (TIMEOUT_CYCLES != 0) begin
          count_nxt_s = count_r + CW'(1);
        end else begin
          count_nxt_s = count_r;
        end
      end
      default: begin
        count_nxt_s = '0;
      end
    endcase
    if (timeout_nxt_s)  err_nxt_s = 1'b1;
    else if (CLR_ERR)   err_nxt_s = 1'b0;
    else                err_nxt_s = ERR;
  end

  // Registered outputs.
  always_ff @(posedge DEST_CLK or posedge RESET) begin
    if (RESET) begin
      TOGGLE_OUT <= 1'b0;
      DATA_OUT   <= '0;
      count_r    <= '0;
      DONE       <= 1'b0;
      TIMEOUT    <= 1'b0;
      DROP       <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      TOGGLE_OUT <= toggle_nxt_s;
      DATA_OUT   <= data_nxt_s;
      count_r    <= count_nxt_s;
      DONE       <= done_nxt_s;
      TIMEOUT    <= timeout_nxt_s;
      DROP       <= drop_nxt_s;
      ERR        <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_adbg_toggle_req_tx.sv
// Bench for adbg_toggle_req_tx: directed handshake scenarios with literal expectations,
// then random traffic checked every cycle against a transaction-level model.
module tb_adbg_toggle_req_tx;

  localparam int DW = 32;
  localparam int TO = 4;
  localparam int HMAX = 16384;

  logic          DEST_CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          REQ_IN = 1'b0;
  logic [DW-1:0] DATA_IN = '0;
  logic          CLR_ERR = 1'b0;
  logic          ACK_TOGGLE_IN = 1'b0;
  logic          TOGGLE_OUT;
  logic [DW-1:0] DATA_OUT;
  logic          BUSY, DONE, TIMEOUT, DROP, ERR;

  int n_cmp = 0;
  int n_bad = 0;

  adbg_toggle_req_tx #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .DEST_CLK(DEST_CLK), .RESET(RESET), .REQ_IN(REQ_IN), .DATA_IN(DATA_IN),
    .CLR_ERR(CLR_ERR), .ACK_TOGGLE_IN(ACK_TOGGLE_IN), .TOGGLE_OUT(TOGGLE_OUT),
    .DATA_OUT(DATA_OUT), .BUSY(BUSY), .DONE(DONE), .TIMEOUT(TIMEOUT),
    .DROP(DROP), .ERR(ERR)
  );

  always #5 DEST_CLK = ~DEST_CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Transaction-level model: the echo counts as seen two edges after it is sampled.
  bit       hist [HMAX];
  int       cyc = 0;
  int       live = 0;
  bit       m_busy = 1'b0;
  int       m_acc = 0;
  bit       m_tog = 1'b0;
  bit [31:0] m_data = '0;
  bit       m_err = 1'b0;
  bit       e_done = 1'b0, e_to = 1'b0, e_drop = 1'b0;

  function automatic bit ack_at(input int i);
    if (i < live || i < 0) return 1'b0;
    return hist[i];
  endfunction

  task automatic model_step();
    bit seen_edge;
    bit set_err;
    if (cyc < HMAX) hist[cyc] = ACK_TOGGLE_IN;
    set_err = 1'b0;
    e_done = 1'b0; e_to = 1'b0; e_drop = 1'b0;
    if (RESET) begin
      m_busy = 1'b0; m_tog = 1'b0; m_data = '0; m_err = 1'b0;
      live = cyc + 1;
    end else begin
      seen_edge = ack_at(cyc - 2) != ack_at(cyc - 3);
      if (!m_busy) begin
        if (REQ_IN) begin
          m_busy = 1'b1; m_acc = cyc; m_tog = ~m_tog; m_data = DATA_IN;
        end
      end else begin
        if (REQ_IN) e_drop = 1'b1;
        if (seen_edge) begin
          e_done = 1'b1; m_busy = 1'b0;
        end else if (cyc - m_acc == TO) begin
          e_to = 1'b1; m_busy = 1'b0; set_err = 1'b1;
        end
      end
      if (set_err)      m_err = 1'b1;
      else if (CLR_ERR) m_err = 1'b0;
    end
    cyc++;
  endtask

  // Single compare process: model advances on each rising edge, outputs checked 1 time unit later.
  initial begin
    forever begin
      @(posedge DEST_CLK);
      model_step();
      #1;
      check("toggle",  {31'd0, TOGGLE_OUT}, {31'd0, m_tog});
      check("data",    DATA_OUT, m_data);
      check("busy",    {31'd0, BUSY},    {31'd0, m_busy});
      check("done",    {31'd0, DONE},    {31'd0, e_done});
      check("timeout", {31'd0, TIMEOUT}, {31'd0, e_to});
      check("drop",    {31'd0, DROP},    {31'd0, e_drop});
      check("err",     {31'd0, ERR},     {31'd0, m_err});
    end
  end

  task automatic do_reset();
    @(negedge DEST_CLK);
    RESET = 1'b1; REQ_IN = 1'b0; CLR_ERR = 1'b0; ACK_TOGGLE_IN = 1'b0;
    repeat (2) @(negedge DEST_CLK);
    RESET = 1'b0;
    repeat (3) @(negedge DEST_CLK);
  endtask

  task automatic pulse_req(input logic [31:0] d);
    REQ_IN = 1'b1; DATA_IN = d;
    @(negedge DEST_CLK);
    REQ_IN = 1'b0;
  endtask

  int rst_hold = 0;

  initial begin
    // Reset state and first transfer.
    do_reset();
    check("rst_toggle", {31'd0, TOGGLE_OUT}, 32'd0);
    check("rst_data",   DATA_OUT, 32'd0);
    check("rst_err",    {31'd0, ERR}, 32'd0);
    pulse_req(32'hDEADBEEF);
    check("t1_toggle", {31'd0, TOGGLE_OUT}, 32'd1);
    check("t1_data",   DATA_OUT, 32'hDEADBEEF);
    check("t1_busy",   {31'd0, BUSY}, 32'd1);
    ACK_TOGGLE_IN = 1'b1;
    repeat (2) @(negedge DEST_CLK);
    check("t1_done_early", {31'd0, DONE}, 32'd0);
    @(negedge DEST_CLK);
    check("t1_done_lat3", {31'd0, DONE}, 32'd1);
    check("t1_idle",      {31'd0, BUSY}, 32'd0);

    // Back-to-back echoed transfers: toggle 1,0,1.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      pulse_req(i);
      check("b2b_toggle", {31'd0, TOGGLE_OUT}, {31'd0, (i % 2 == 1)});
      check("b2b_data",   DATA_OUT, i);
      ACK_TOGGLE_IN = (i % 2 == 1);
      repeat (3) @(negedge DEST_CLK);
      check("b2b_done", {31'd0, DONE}, 32'd1);
      check("b2b_drop", {31'd0, DROP}, 32'd0);
    end

    // Timeout, late ack ignored, error clear.
    do_reset();
    pulse_req(32'h0000_00A5);
    repeat (3) @(negedge DEST_CLK);
    check("to_before", {31'd0, TIMEOUT}, 32'd0);
    @(negedge DEST_CLK);
    check("to_pulse", {31'd0, TIMEOUT}, 32'd1);
    check("to_err",   {31'd0, ERR}, 32'd1);
    check("to_busy",  {31'd0, BUSY}, 32'd0);
    check("to_toggle_kept", {31'd0, TOGGLE_OUT}, 32'd1);
    ACK_TOGGLE_IN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge DEST_CLK);
      check("late_ack_no_done", {31'd0, DONE}, 32'd0);
    end
    CLR_ERR = 1'b1;
    @(negedge DEST_CLK);
    CLR_ERR = 1'b0;
    check("clr_err", {31'd0, ERR}, 32'd0);

    // Request while busy is dropped.
    do_reset();
    pulse_req(32'h0000_0011);
    pulse_req(32'h0000_0055);
    check("drop_pulse",  {31'd0, DROP}, 32'd1);
    check("drop_data",   DATA_OUT, 32'h0000_0011);
    check("drop_toggle", {31'd0, TOGGLE_OUT}, 32'd1);

    // Ack edge lands on the timeout cycle: ack wins.
    do_reset();
    pulse_req(32'h0000_0077);
    @(negedge DEST_CLK);
    ACK_TOGGLE_IN = 1'b1;
    repeat (3) @(negedge DEST_CLK);
    check("race_done",    {31'd0, DONE}, 32'd1);
    check("race_timeout", {31'd0, TIMEOUT}, 32'd0);
    check("race_err",     {31'd0, ERR}, 32'd0);

    // Asynchronous reset in WAIT_ACK, then a normal transfer.
    do_reset();
    pulse_req(32'h0000_0099);
    #2 RESET = 1'b1; ACK_TOGGLE_IN = 1'b0;
    #1;
    check("arst_toggle", {31'd0, TOGGLE_OUT}, 32'd0);
    check("arst_data",   DATA_OUT, 32'd0);
    check("arst_busy",   {31'd0, BUSY}, 32'd0);
    @(negedge DEST_CLK);
    @(negedge DEST_CLK);
    RESET = 1'b0;
    @(negedge DEST_CLK);
    pulse_req(32'h0000_0123);
    check("post_rst_busy",   {31'd0, BUSY}, 32'd1);
    check("post_rst_toggle", {31'd0, TOGGLE_OUT}, 32'd1);
    check("post_rst_data",   DATA_OUT, 32'h0000_0123);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      @(negedge DEST_CLK);
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) RESET = 1'b0;
      end else if ($urandom_range(0, 399) == 0) begin
        RESET = 1'b1;
        rst_hold = 2;
      end
      REQ_IN  = ($urandom_range(0, 3) == 0);
      DATA_IN = $urandom;
      CLR_ERR = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 7))
        0:       ACK_TOGGLE_IN = ~ACK_TOGGLE_IN;
        1, 2:    ACK_TOGGLE_IN = TOGGLE_OUT;
        default: ACK_TOGGLE_IN = ACK_TOGGLE_IN;
      endcase
    end
    @(negedge DEST_CLK);
    RESET = 1'b0;
    repeat (4) @(negedge DEST_CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
